crt_row_fetch_buffer: RTL and testbench
=======================================

// Module: crt_row_fetch_buffer
// PURPOSE
//   Downstream consumer of the K580VT57 DMA channel 2 display stream.
//   Raises DRQ, captures bytes from DMA write cycles (DACK + IOWE_n) into a
//   double-buffered character row, and serves the other bank to the video
//   scan logic by column index.
//   Bank swap is on row_start. Fetching is paced in bursts with gaps.
// PARAMETERS
//   COLS    80  characters per row; 1..128
//   BURST   8   bytes fetched per DRQ burst; 1..COLS
//   GAP     16  clk cycles DRQ held low between bursts; >=1
// PORTS
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high
//   enable       in   1  fetch enable (display on)
//   frame_start  in   1  1-clk pulse: start of frame, restart fill
//   row_start    in   1  1-clk pulse: start of displayed row, swap banks
//   drq          out  1  DMA request to controller channel
//   dack         in   1  DMA acknowledge for this channel
//   iowe_n       in   1  DMA I/O write strobe, active low
//   idata        in   8  DMA data bus
//   col          in   7  display column being read
//   char_out     out  8  character at col from display bank
//   row_ready    out  1  fill bank complete (COLS bytes held)
//   underrun     out  1  sticky: row_start arrived before fill complete
//   overrun      out  1  sticky: byte offered while fill bank full
// BEHAVIOUR
// - Reset values: drq=0, char_out=0, row_ready=0, underrun=0, overrun=0.
//   Internal reset values: fill_bank=0, wr_ptr=0, burst_cnt=0, state=IDLE.
//   RAM contents are not reset.
// - Storage: 2 x COLS bytes. disp_bank = ~fill_bank.
// - Byte accept:
//   - Occurs on a clk where dack=1, iowe_n=0 and taken=0. Then taken<=1.
//   - taken clears on any clk with dack=0, so there is exactly one write
//     per DACK pulse.
//   - Accepted byte goes to bank[fill_bank][wr_ptr]; wr_ptr += 1 and
//     burst_cnt += 1.
//   - A byte accepted with wr_ptr==COLS is discarded and sets overrun.
//   - Bytes are accepted in every state, including IDLE.
// - FSM; drq is registered, =1 only in REQ:
//   - IDLE: enter REQ on frame_start while enable=1.
//   - REQ: drq=1.
//     - Byte accept making wr_ptr==COLS -> FULL.
//     - Else burst_cnt==BURST -> GAP; burst_cnt=0, gap timer=GAP.
//   - GAP: gap timer counts down per clk; at 0 -> REQ.
//   - FULL: row_ready=1. Wait for row_start.
//   - enable=0 in any state -> IDLE next clk. wr_ptr and banks are held.
// - row_start (any state except IDLE):
//   - fill_bank toggles, wr_ptr=0, burst_cnt=0, next state REQ.
//   - If wr_ptr!=COLS at that clk, set underrun. Swap anyway; the unfilled
//     tail shows stale data.
// - frame_start: wr_ptr=0, burst_cnt=0, underrun=0, overrun=0.
//   fill_bank is unchanged. State -> REQ if enable=1.
// - Precedence, same clk: reset > frame_start > row_start > byte accept.
//   A byte coincident with frame_start or row_start is discarded without
//   setting overrun.
// - Read port: char_out <= bank[disp_bank][col] on every clk (1-clk latency).
//   col>=COLS yields 8'h00.
// - Widths: wr_ptr is 8 bits, compared against COLS exactly; no wrap past
//   COLS. The gap timer is sized to GAP.
// TESTING
// 1. Reset mid-burst (drq=1, wr_ptr=5) -> drq=0, row_ready=0 and all flags
//    0 the same clk; FSM in IDLE.
// 2. COLS=80, BURST=8, GAP=16; frame_start then 80 DMA writes of 0x00..0x4F
//    -> 10 DRQ bursts with >=16 low clks between; row_ready=1; drq=0.
//    Then row_start; col=0x25 -> char_out=0x25 one clk later.
// 3. Hold dack=1, iowe_n=0 for 3 clks -> exactly one byte written;
//    wr_ptr +1.
// 4. row_start after only 40 bytes -> underrun=1, banks swap,
//    wr_ptr=0, drq=1 next clk.
// 5. Extra DMA write with bank full (wr_ptr=80) -> overrun=1,
//    RAM unchanged.
//    Then frame_start -> overrun=0, underrun=0.
// 6. row_start and a byte accept on the same clk -> byte dropped,
//    overrun=0, new fill bank wr_ptr=0. col=90 -> char_out=0x00.

Source files
------------

// File: rtl/crt_row_fetch_buffer.sv
// Double-buffered character row fed by DMA channel 2 write cycles.
// One bank fills from the DMA stream in bursts while the other is served to video scan by column.
module crt_row_fetch_buffer #(
  parameter int COLS  = 80,
  parameter int BURST = 8,
  parameter int GAP   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_start,
  input  logic       row_start,
  output logic       drq,
  input  logic       dack,
  input  logic       iowe_n,
  input  logic [7:0] idata,
  input  logic [6:0] col,
  output logic [7:0] char_out,
  output logic       row_ready,
  output logic       underrun,
  output logic       overrun
);

  localparam int TW = $clog2(GAP + 1);
  localparam int AW = (COLS > 1) ? $clog2(2 * COLS) : 1;
  localparam logic [7:0]    COLS_W  = 8'(COLS);
  localparam logic [7:0]    BURST_W = 8'(BURST);
  localparam logic [TW-1:0] GAP_W   = TW'(GAP);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_FULL} state_e;

  state_e        state_q, state_d;
  logic          fill_bank_q, fill_bank_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [TW-1:0] gap_q, gap_d;
  logic          taken_q, taken_d;
  logic          underrun_q, underrun_d;
  logic          overrun_q, overrun_d;
  logic          drq_q, row_ready_q;
  logic [7:0]    char_q;

  logic          accept, swap, full, wr_en;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    mem [2*COLS];

  always_comb begin
    accept      = dack && !iowe_n && !taken_q;
    swap        = row_start && !frame_start && (state_q != S_IDLE);
    full        = (wr_ptr_q == COLS_W);
    wr_en       = accept && !frame_start && !swap && !full;
    state_d     = state_q;
    fill_bank_d = fill_bank_q;
    wr_ptr_d    = wr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gap_d       = gap_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    // One write per DACK pulse: re-arm only once DACK drops.
    taken_d     = dack ? (taken_q | accept) : 1'b0;

    if (wr_en) begin
      wr_ptr_d    = wr_ptr_q + 8'd1;
      burst_cnt_d = burst_cnt_q + 8'd1;
    end
    if (accept && !frame_start && !swap && full) overrun_d = 1'b1;

    case (state_q)
      S_REQ: begin
        if (wr_ptr_d == COLS_W) begin
          state_d = S_FULL;
        end else if (burst_cnt_d >= BURST_W) begin
          state_d     = S_GAP;
          burst_cnt_d = 8'd0;
          gap_d       = GAP_W;
        end
      end
      S_GAP: begin
        gap_d = gap_q - TW'(1);
        if (gap_q <= TW'(1)) state_d = S_REQ;
      end
      default: ;
    endcase

    // Swap regardless of fill level; an unfilled tail shows stale bytes.
    if (swap) begin
      fill_bank_d = ~fill_bank_q;
      wr_ptr_d    = 8'd0;
      burst_cnt_d = 8'd0;
      state_d     = S_REQ;
      if (!full) underrun_d = 1'b1;
    end
    if (frame_start) begin
      wr_ptr_d    = 8'd0;
      burst_cnt_d = 8'd0;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      state_d     = S_REQ;
    end
    if (!enable) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fill_bank_q <= 1'b0;
      wr_ptr_q    <= 8'd0;
      burst_cnt_q <= 8'd0;
      gap_q       <= '0;
      taken_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      drq_q       <= 1'b0;
      row_ready_q <= 1'b0;
      char_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      fill_bank_q <= fill_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      gap_q       <= gap_d;
      taken_q     <= taken_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      drq_q       <= (state_d == S_REQ);
      row_ready_q <= (state_d == S_FULL);
      char_q      <= ({1'b0, col} < COLS_W) ? mem[raddr] : 8'h00;
    end
  end

  // Bank b occupies mem[b*COLS +: COLS].
  assign waddr = fill_bank_q ? AW'(COLS_W + wr_ptr_q) : AW'(wr_ptr_q);
  assign raddr = fill_bank_q ? AW'({1'b0, col}) : AW'(COLS_W + {1'b0, col});

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= idata;
  end

  assign drq       = drq_q;
  assign row_ready = row_ready_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign char_out  = char_q;

endmodule

// File: tb/tb_crt_row_fetch_buffer.sv
// Directed-plus-random bench for crt_row_fetch_buffer: acts as the DMA controller and
// keeps a transaction-level picture of both banks, the fill pointer and the sticky flags.
module tb_crt_row_fetch_buffer;
  localparam int COLS  = 80;
  localparam int BURST = 8;
  localparam int GAP   = 16;

  logic       clk = 1'b0;
  logic       reset, enable, frame_start, row_start, dack, iowe_n;
  logic [7:0] idata;
  logic [6:0] col;
  logic       drq, row_ready, underrun, overrun;
  logic [7:0] char_out;

  crt_row_fetch_buffer #(.COLS(COLS), .BURST(BURST), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .row_start(row_start), .drq(drq), .dack(dack), .iowe_n(iowe_n),
    .idata(idata), .col(col), .char_out(char_out), .row_ready(row_ready),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference picture: bank contents, which bank fills, bytes held, flags.
  logic [7:0] m_mem [2][COLS];
  int         m_fill, m_wp;
  logic       m_under, m_over;

  // DRQ burst monitor, active while mon_en is high.
  logic mon_en = 1'b0;
  int   bursts, low_run, min_gap;
  bit   seen, prev;
  always @(negedge clk) begin
    if (!mon_en) begin
      bursts = 0; min_gap = 1000; seen = 0; low_run = 0; prev = 0;
    end else if (drq === 1'b1) begin
      if (!prev) begin
        bursts++;
        if (seen && low_run < min_gap) min_gap = low_run;
        seen = 1;
      end
      low_run = 0; prev = 1;
    end else begin
      low_run++; prev = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_drq();
    int t = 0;
    while (drq !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (drq !== 1'b1) check("drq_timeout", 32'(drq), 1);
  endtask

  // One DMA write cycle: DACK+IOWE_n held for 'hold' clocks, then released.
  task automatic pulse(input logic [7:0] d, input int hold);
    idata = d; dack = 1'b1; iowe_n = 1'b0;
    repeat (hold) @(negedge clk);
    dack = 1'b0; iowe_n = 1'b1;
    @(negedge clk);
    if (m_wp < COLS) begin
      m_mem[m_fill][m_wp] = d;
      m_wp++;
    end else begin
      m_over = 1'b1;
    end
    check("row_ready_per_byte", 32'(row_ready), 32'(m_wp == COLS));
    check("overrun_per_byte", 32'(overrun), 32'(m_over));
  endtask

  task automatic fill(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) begin
      wait_drq();
      pulse(rnd ? 8'($urandom) : 8'(base + i), int'($urandom_range(1, 3)));
    end
  endtask

  task automatic do_row_start();
    row_start = 1'b1;
    @(negedge clk);
    row_start = 1'b0;
    if (m_wp != COLS) m_under = 1'b1;
    m_fill = 1 - m_fill;
    m_wp   = 0;
    check("drq_after_row_start", 32'(drq), 1);
    check("underrun_after_row_start", 32'(underrun), 32'(m_under));
  endtask

  task automatic do_frame_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    m_wp = 0; m_under = 1'b0; m_over = 1'b0;
    check("underrun_after_frame", 32'(underrun), 0);
    check("overrun_after_frame", 32'(overrun), 0);
  endtask

  task automatic readback(input string tag);
    for (int c = 0; c < COLS; c++) begin
      col = 7'(c);
      @(negedge clk);
      check(tag, 32'(char_out), 32'(m_mem[1 - m_fill][c]));
    end
    col = 7'd90;
    @(negedge clk);
    check("col_out_of_range", 32'(char_out), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; row_start = 1'b0;
    dack = 1'b0; iowe_n = 1'b1; idata = 8'h00; col = 7'd0;
    m_fill = 0; m_wp = 0; m_under = 1'b0; m_over = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_drq", 32'(drq), 0);
    check("rst_char_out", 32'(char_out), 0);
    check("rst_row_ready", 32'(row_ready), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;

    // Reset in the middle of a burst clears outputs immediately.
    enable = 1'b1;
    @(negedge clk);
    do_frame_start();
    fill(5, 1'b1, 0);
    check("midburst_drq", 32'(drq), 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_drq", 32'(drq), 0);
    check("async_rst_row_ready", 32'(row_ready), 0);
    check("async_rst_underrun", 32'(underrun), 0);
    check("async_rst_overrun", 32'(overrun), 0);
    @(negedge clk);
    reset = 1'b0;
    m_fill = 0; m_wp = 0; m_under = 1'b0; m_over = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_no_drq", 32'(drq), 0);

    // Full row 0x00..0x4F in DRQ bursts.
    mon_en = 1'b1;
    @(negedge clk);
    do_frame_start();
    fill(COLS, 1'b0, 0);
    check("burst_count", 32'(bursts), 32'(COLS / BURST));
    check("gap_at_least_GAP", 32'(min_gap >= GAP), 1);
    check("full_row_ready", 32'(row_ready), 1);
    check("full_drq_low", 32'(drq), 0);
    mon_en = 1'b0;
    do_row_start();
    col = 7'h25;
    @(negedge clk);
    check("col25", 32'(char_out), 32'h25);
    readback("row_incr");

    // Fill the other bank with random data and show it.
    fill(COLS, 1'b1, 0);
    do_row_start();
    readback("row_rand");

    // Partial fill (last byte with a 3-clock DACK), then early swap.
    fill(COLS / 2 - 1, 1'b1, 0);
    wait_drq();
    pulse(8'($urandom), 3);
    check("partial_row_ready", 32'(row_ready), 0);
    do_row_start();
    check("underrun_set", 32'(underrun), 1);
    readback("row_partial");

    // Extra write while full sets overrun and leaves RAM alone.
    do_frame_start();
    fill(COLS, 1'b1, 0);
    check("full_drq_low2", 32'(drq), 0);
    pulse(8'($urandom), 1);
    check("overrun_set", 32'(overrun), 1);
    check("underrun_still_clear", 32'(underrun), 0);
    do_row_start();
    readback("row_after_overrun");
    do_frame_start();

    // Byte coincident with row_start is dropped.
    fill(3, 1'b1, 0);
    wait_drq();
    idata = 8'hAA; dack = 1'b1; iowe_n = 1'b0; row_start = 1'b1;
    @(negedge clk);
    row_start = 1'b0; dack = 1'b0; iowe_n = 1'b1;
    m_under = 1'b1; m_fill = 1 - m_fill; m_wp = 0;
    check("coinc_drq", 32'(drq), 1);
    check("coinc_overrun", 32'(overrun), 0);
    check("coinc_underrun", 32'(underrun), 1);
    @(negedge clk);
    fill(COLS, 1'b1, 0);
    do_row_start();
    readback("row_after_coinc");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
